// File: rtl/relu_maxpool_if.sv
// relu_maxpool_if: stream bundle for the ReLU + 2x2 max-pool stage.
// Carries the input sample handshake, the pooled output handshake and the
// end-of-frame pulse. The master modport is the producer/consumer side,
// the slave modport is the pooling block itself.
interface relu_maxpool_if #(
  parameter int DATA_W = 32
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic        [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done
  );
endinterface

// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU followed by 2x2 stride-2 max pooling over a raster
// stream of signed Q8.24 convolution sums. One pooled value is emitted per
// window through a single-entry output register with ready/valid handshake.
// Even rows fold horizontal pairs into a half-width row buffer; odd rows
// combine their pair with the buffered value and emit the window maximum.
// Optional feature: define RELU_MAXPOOL_BIAS_EN to add a saturating bias
// adder in front of the ReLU (combinational, latency unchanged).
module relu_maxpool #(
  parameter int DATA_W = 32,
  parameter int MAP_W  = 32,
  parameter int MAP_H  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef RELU_MAXPOOL_BIAS_EN
  input  logic signed [DATA_W-1:0] bias,
`endif
  relu_maxpool_if.slave            s
);

  localparam int CW = (MAP_W > 2) ? $clog2(MAP_W) : 1;
  localparam int RW = (MAP_H > 2) ? $clog2(MAP_H) : 1;
  localparam int BD = MAP_W / 2;
  localparam int BW = (BD > 1) ? $clog2(BD) : 1;

  generate
    if ((MAP_W % 2) != 0 || (MAP_H % 2) != 0 || MAP_W < 2 || MAP_H < 2) begin : g_bad_geometry
      $error("relu_maxpool: MAP_W and MAP_H must be even and >= 2");
    end
  endgenerate

`ifdef RELU_MAXPOOL_BIAS_EN
  // Signed add with clamp to the most positive / most negative code.
  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = sum[DATA_W-1:0];
  endfunction
`endif

  function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    relu = x[DATA_W-1] ? '0 : x;
  endfunction

  // Operands are post-ReLU, hence non-negative: unsigned compare is exact.
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    umax = (a > b) ? a : b;
  endfunction

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic [DATA_W-1:0]        r_hold;
  logic [DATA_W-1:0]        r_rowbuf [BD];
  logic [DATA_W-1:0]        r_data_p1;
  logic                     r_vld_p1;
  logic                     r_done_p1;

  logic signed [DATA_W-1:0] w_s_p0;
  logic [DATA_W-1:0]        w_r_p0;
  logic [DATA_W-1:0]        w_pair_max;
  logic [DATA_W-1:0]        w_win_max;
  logic [BW-1:0]            w_bidx;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_col_last;
  logic                     w_row_last;

  // ---- stage p0: bias, ReLU, pair/window maximum (combinational) ----
`ifdef RELU_MAXPOOL_BIAS_EN
  assign w_s_p0 = sat_add(s.in_data, bias);
`else
  assign w_s_p0 = s.in_data;
`endif
  assign w_r_p0     = relu(w_s_p0);
  assign w_bidx     = BW'(r_col >> 1);
  assign w_pair_max = umax(r_hold, w_r_p0);
  assign w_win_max  = umax(r_rowbuf[w_bidx], w_pair_max);

  assign w_in_ready = !r_vld_p1 || s.out_ready;
  assign w_accept   = s.in_valid && w_in_ready;
  assign w_col_last = (r_col == CW'(MAP_W - 1));
  assign w_row_last = (r_row == RW'(MAP_H - 1));

  // Even rows: store horizontal pair maxima; entries are always written before read.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && !r_row[0] && r_col[0])
      r_rowbuf[w_bidx] <= w_pair_max;
  end

  // ---- stage p1: counters, hold register and output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hold    <= '0;
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
    end else begin
      r_done_p1 <= 1'b0;
      if (s.out_ready)
        r_vld_p1 <= 1'b0;
      if (w_accept) begin
        if (!r_col[0]) begin
          r_hold <= w_r_p0;
        end else if (r_row[0]) begin
          // Load wins over drain, so out_valid stays high on a coincident handoff.
          r_data_p1 <= w_win_max;
          r_vld_p1  <= 1'b1;
        end
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row     <= '0;
            r_done_p1 <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign s.in_ready   = w_in_ready;
  assign s.out_data   = r_data_p1;
  assign s.out_valid  = r_vld_p1;
  assign s.frame_done = r_done_p1;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed bench for relu_maxpool with a 4x2 map.
module tb_relu_maxpool;

  localparam int DATA_W = 32;
  localparam int MAP_W  = 4;
  localparam int MAP_H  = 2;

  logic clk;
  logic reset;
`ifdef RELU_MAXPOOL_BIAS_EN
  logic signed [DATA_W-1:0] bias;
`endif

  relu_maxpool_if #(.DATA_W(DATA_W)) bus ();

  relu_maxpool #(.DATA_W(DATA_W), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef RELU_MAXPOOL_BIAS_EN
    .bias  (bias),
`endif
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int fd0;
  logic [31:0] q_out [$];

  // Scenario 2 frame, raster order.
  logic [31:0] frame2 [8] = '{32'h01000000, 32'h02000000, 32'h03000000, 32'h04000000,
                              32'h05000000, 32'hFA000000, 32'h00000000, 32'h08000000};

  // Record every completed output transfer and every frame_done pulse.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      q_out.push_back(bus.out_data);
    if (bus.frame_done === 1'b1)
      fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted; returns just after the accepting edge.
  task automatic send_pixel(input logic [31:0] d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=%b expected=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame2();
    for (int i = 0; i < 8; i++) send_pixel(frame2[i]);
  endtask

  // Wait for two outputs, allow a margin for spurious extras, then compare.
  task automatic expect_two(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    int n;
    n = 0;
    while (q_out.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 32'(q_out.size()), 32'd2);
    if (q_out.size() >= 2) begin
      check({tag, "_out0"}, q_out[0], e0);
      check({tag, "_out1"}, q_out[1], e1);
    end
    q_out.delete();
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h01000000;
    bus.out_ready = 1'b1;
`ifdef RELU_MAXPOOL_BIAS_EN
    bias = '0;
`endif

    // 1: reset held two cycles with in_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_no_output", 32'(q_out.size()), 32'd0);
    check("rst_no_done", 32'(fd_cnt), 32'd0);
    tick();

    // 2: basic frame with per-output timing
    fd0 = fd_cnt;
    for (int i = 0; i < 5; i++) send_pixel(frame2[i]);
    @(negedge clk);
    check("basic_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    send_pixel(frame2[5]);
    @(negedge clk);
    check("basic_w0_valid", 32'(bus.out_valid), 32'd1);
    check("basic_w0_data", bus.out_data, 32'h05000000);
    check("basic_w0_no_done", 32'(bus.frame_done), 32'd0);
    tick();
    send_pixel(frame2[6]);
    send_pixel(frame2[7]);
    @(negedge clk);
    check("basic_w1_valid", 32'(bus.out_valid), 32'd1);
    check("basic_w1_data", bus.out_data, 32'h08000000);
    check("basic_w1_done", 32'(bus.frame_done), 32'd1);
    tick();
    @(negedge clk);
    check("basic_drained", 32'(bus.out_valid), 32'd0);
    check("basic_done_pulse", 32'(bus.frame_done), 32'd0);
    tick();
    expect_two("basic", 32'h05000000, 32'h08000000);
    check("basic_done_count", 32'(fd_cnt - fd0), 32'd1);

    // 3: all-negative frame, pixels back to back
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) send_pixel(32'hFF000000);
    expect_two("neg", 32'h0, 32'h0);
    check("neg_done_count", 32'(fd_cnt - fd0), 32'd1);

    // 4: backpressure after the first output
    fd0 = fd_cnt;
    for (int i = 0; i < 6; i++) send_pixel(frame2[i]);
    bus.out_ready = 1'b0;
    bus.in_data   = frame2[6];
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data", bus.out_data, 32'h05000000);
    end
    tick();
    bus.out_ready = 1'b1;
    send_pixel(frame2[6]);
    send_pixel(frame2[7]);
    expect_two("bp", 32'h05000000, 32'h08000000);
    check("bp_done_count", 32'(fd_cnt - fd0), 32'd1);

    // 5: reset after three accepted pixels, then a full frame
    for (int i = 0; i < 3; i++) send_pixel(frame2[i]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    fd0 = fd_cnt;
    send_frame2();
    expect_two("midrst", 32'h05000000, 32'h08000000);
    check("midrst_done_count", 32'(fd_cnt - fd0), 32'd1);

`ifdef RELU_MAXPOOL_BIAS_EN
    // 6: saturating bias ahead of ReLU
    bias = 32'sh01000000;
    send_pixel(32'h7F800000);
    send_pixel(32'hFE000000);
    send_pixel(32'h00000000);
    send_pixel(32'h00000000);
    send_pixel(32'h00000000);
    send_pixel(32'h00800000);
    send_pixel(32'h00000000);
    send_pixel(32'h00000000);
    expect_two("bias", 32'h7FFFFFFF, 32'h01000000);
    bias = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
